// File: rtl/car_disp_pkg.sv
// Shared encodings for the car display slice.
// Source selects, car modes and default tick counts.
package car_disp_pkg;

  localparam logic [1:0] SRC_NORMAL = 2'd0;
  localparam logic [1:0] SRC_BANNER = 2'd1;
  localparam logic [1:0] SRC_ALERT  = 2'd2;
  localparam logic [1:0] SRC_OFF    = 2'd3;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_MAN  = 2'b01;
  localparam logic [1:0] MODE_SEMI = 2'b10;
  localparam logic [1:0] MODE_AUTO = 2'b11;

  localparam int BANNER_TICKS_DEF    = 1000;
  localparam int BLINK_TICKS_DEF     = 125;
  localparam int ALERT_MIN_TICKS_DEF = 500;
  localparam int TW_DEF              = 11;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_BANNER = 2'd1,
    ST_ALERT  = 2'd2,
    ST_OFF    = 2'd3
  } disp_state_e;

endpackage

// File: rtl/disp_down_timer.sv
// Loadable down-counter that saturates at zero.
// Load wins over decrement; zero flag is combinational.
module disp_down_timer #(
  parameter int TW = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // next count: load, else saturating decrement
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/seg_display_arbiter.sv
// Chooses which source owns the 8-digit display.
// OFF beats ALERT beats BANNER beats NORMAL.
module seg_display_arbiter
  import car_disp_pkg::*;
#(
  parameter int BANNER_TICKS    = BANNER_TICKS_DEF,
  parameter int BLINK_TICKS     = BLINK_TICKS_DEF,
  parameter int ALERT_MIN_TICKS = ALERT_MIN_TICKS_DEF,
  parameter int TW              = TW_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mode,
  input  logic [15:0] mile,
  input  logic        alert_req,
  input  logic [1:0]  alert_code,
  output logic [1:0]  src,
  output logic [1:0]  shown_mode,
  output logic [15:0] shown_mile,
  output logic [1:0]  shown_alert,
  output logic        blank,
  output logic [7:0]  seg_en_mask
);

  localparam logic [TW-1:0] BANNER_LD = TW'(BANNER_TICKS - 1);
  localparam logic [TW-1:0] ALERT_LD  = TW'(ALERT_MIN_TICKS - 1);
  localparam logic [TW-1:0] BLINK_LD  = TW'(BLINK_TICKS - 1);

  disp_state_e   state_q, state_d;
  logic [1:0]    prev_mode_q;
  logic [1:0]    shown_mode_q, shown_mode_d;
  logic [15:0]   shown_mile_q, shown_mile_d;
  logic [1:0]    shown_alert_q, shown_alert_d;
  logic          blank_q, blank_d;
  logic [7:0]    mask_q, mask_d;

  logic          mode_chg;
  logic          tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0] tmr_val;
  logic          blk_load, blk_dec, blk_zero;
  logic          in_alert, entering;

  assign mode_chg = (mode != prev_mode_q);

  disp_down_timer #(.TW(TW)) u_main_tmr (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  disp_down_timer #(.TW(TW)) u_blink_tmr (
    .clk      (clk),
    .reset    (reset),
    .load     (blk_load),
    .load_val (BLINK_LD),
    .dec      (blk_dec),
    .zero     (blk_zero)
  );

  // next owner and banner/hold timer control
  always_comb begin
    state_d       = state_q;
    tmr_load      = 1'b0;
    tmr_val       = ALERT_LD;
    tmr_dec       = 1'b0;
    shown_alert_d = shown_alert_q;
    if (mode == MODE_OFF) begin
      state_d = ST_OFF;
    end else if (alert_req) begin
      state_d       = ST_ALERT;
      tmr_load      = 1'b1;
      tmr_val       = ALERT_LD;
      shown_alert_d = alert_code;
    end else if (state_q == ST_ALERT) begin
      if (tmr_zero) state_d = ST_NORMAL;
      else          tmr_dec = 1'b1;
    end else if (mode_chg) begin
      state_d  = ST_BANNER;
      tmr_load = 1'b1;
      tmr_val  = BANNER_LD;
    end else if (state_q == ST_BANNER) begin
      if (tmr_zero) state_d = ST_NORMAL;
      else          tmr_dec = 1'b1;
    end
  end

  // blink phase, operand latching and digit mask
  always_comb begin
    in_alert = (state_d == ST_ALERT);
    entering = in_alert && (state_q != ST_ALERT);
    blk_load = entering || (in_alert && !entering && blk_zero);
    blk_dec  = in_alert && !entering && !blk_zero;
    blank_d  = 1'b0;
    if (in_alert && !entering) begin
      blank_d = blk_zero ? ~blank_q : blank_q;
    end
    shown_mode_d = mode;
    shown_mile_d = in_alert ? shown_mile_q : mile;
    unique case (1'b1)
      (state_d == ST_OFF): mask_d = 8'hF0;
      in_alert:            mask_d = blank_d ? 8'h00 : 8'hFF;
      default:             mask_d = 8'hFF;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_OFF;
      prev_mode_q   <= MODE_OFF;
      shown_mode_q  <= 2'b00;
      shown_mile_q  <= 16'h0000;
      shown_alert_q <= 2'b00;
      blank_q       <= 1'b0;
      mask_q        <= 8'hF0;
    end else begin
      state_q       <= state_d;
      prev_mode_q   <= mode;
      shown_mode_q  <= shown_mode_d;
      shown_mile_q  <= shown_mile_d;
      shown_alert_q <= shown_alert_d;
      blank_q       <= blank_d;
      mask_q        <= mask_d;
    end
  end

  assign src         = state_q;
  assign shown_mode  = shown_mode_q;
  assign shown_mile  = shown_mile_q;
  assign shown_alert = shown_alert_q;
  assign blank       = blank_q;
  assign seg_en_mask = mask_q;

endmodule
